// File: rtl/sobel_pkg.sv
// Shared constants and lane identifiers for the Sobel datapath.
// The multiplier operand widths here are the defaults used by sobel_mul_share_arb.
package sobel_pkg;

    localparam int SOBEL_MUL_A_W   = 7;
    localparam int SOBEL_MUL_B_W   = 9;
    localparam int SOBEL_MUL_P_W   = 15;
    localparam int SOBEL_MUL_NREQ  = 4;

    // Requester lanes sharing the multiplier: two kernel-weight, two normalisation.
    typedef enum logic [1:0] {
        SOBEL_REQ_KW_X   = 2'd0,
        SOBEL_REQ_KW_Y   = 2'd1,
        SOBEL_REQ_NORM_X = 2'd2,
        SOBEL_REQ_NORM_Y = 2'd3
    } sobel_req_e;

endpackage

// File: rtl/sobel_mul_u_core.sv
// Unsigned A x B multiplier producing the full-width product.
// Only the purely combinational form (NUM_STAGE = 0) is provided.
module sobel_mul_u_core #(
    parameter int A_WIDTH   = 7,
    parameter int B_WIDTH   = 9,
    parameter int NUM_STAGE = 0
) (
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic [A_WIDTH+B_WIDTH-1:0] p
);

    if (NUM_STAGE == 0) begin : g_comb
        always_comb begin
            p = (A_WIDTH+B_WIDTH)'(a) * (A_WIDTH+B_WIDTH)'(b);
        end
    end else begin : g_unsupported
        $error("sobel_mul_u_core: only NUM_STAGE = 0 is supported");
        always_comb begin
            p = '0;
        end
    end

endmodule

// File: rtl/sobel_mul_share_arb.sv
// One shared unsigned multiplier, round-robin arbitrated between NUM_REQ lanes,
// with an operand register (S1) and a result register (S2) and tagged results.
module sobel_mul_share_arb
    import sobel_pkg::*;
#(
    parameter int NUM_REQ  = SOBEL_MUL_NREQ,
    parameter int A_WIDTH  = SOBEL_MUL_A_W,
    parameter int B_WIDTH  = SOBEL_MUL_B_W,
    parameter int P_WIDTH  = SOBEL_MUL_P_W,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [P_WIDTH-1:0]          res_p,
    output logic                        res_ovf,
    output logic [ID_WIDTH-1:0]         res_id
);

    localparam int FULL_W = A_WIDTH + B_WIDTH;

    logic [ID_WIDTH-1:0] rr;
    logic                s1_vld;
    logic [A_WIDTH-1:0]  s1_a;
    logic [B_WIDTH-1:0]  s1_b;
    logic [ID_WIDTH-1:0] s1_id;

    logic                s1_adv;
    logic                s2_adv;
    logic                grant_vld;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH:0]   grant_pick;
    logic [NUM_REQ-1:0]  grant_oh;
    logic                accept;
    logic [A_WIDTH-1:0]  sel_a;
    logic [B_WIDTH-1:0]  sel_b;
    logic [FULL_W-1:0]   full;

    // Returns {found, index}: first valid lane at or after ptr, wrapping to 0.
    function automatic logic [ID_WIDTH:0] rr_grant(
        input logic [NUM_REQ-1:0]  vld,
        input logic [ID_WIDTH-1:0] ptr
    );
        logic [ID_WIDTH:0]   res;
        logic [ID_WIDTH-1:0] idx;
        int unsigned         j;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j   = (32'(ptr) + k) % NUM_REQ;
            idx = ID_WIDTH'(j);
            if (!res[ID_WIDTH] && vld[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign s2_adv     = ~res_valid | res_ready;
    assign s1_adv     = ~s1_vld | s2_adv;
    assign grant_pick = rr_grant(req_valid, rr);
    assign grant_vld  = grant_pick[ID_WIDTH];
    assign grant_idx  = grant_pick[ID_WIDTH-1:0];
    assign accept     = ap_rst_n & s1_adv & grant_vld;

    always_comb begin
        grant_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                grant_oh[i] = 1'b1;
                sel_a       = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b       = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Reset is folded in so ready reads low while ap_rst_n is asserted.
    assign req_ready = accept ? grant_oh : '0;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr <= '0;
        end else if (accept) begin
            rr <= (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
        end else if (s1_adv) begin
            s1_vld <= accept;
            if (accept) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= grant_idx;
            end
        end
    end

    sobel_mul_u_core #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .NUM_STAGE (0)
    ) u_core (
        .a (s1_a),
        .b (s1_b),
        .p (full)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_valid <= 1'b0;
            res_p     <= '0;
            res_ovf   <= 1'b0;
            res_id    <= '0;
        end else if (s2_adv) begin
            res_valid <= s1_vld;
            if (s1_vld) begin
                res_p   <= full[P_WIDTH-1:0];
                res_ovf <= |full[FULL_W-1:P_WIDTH];
                res_id  <= s1_id;
            end
        end
    end

endmodule
